// File: rtl/pulse_qual_pkg.sv
// Shared definitions for the pulse qualifier: per-channel FSM state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pulse_qual_pkg;

  // ARM: waiting for a high; HIGH: counting highs; DONE: qualified, waiting for low;
  // LOW: counting lows before re-arming.
  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    DONE = 2'd2,
    LOW  = 2'd3
  } pq_state_e;

  localparam int THR_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pulse_qual_channel.sv
// One pulse-qualifier channel: optional 2-flop input synchronizer, ARM/HIGH/DONE/LOW FSM
// with high/low run counters, wrap-around event counter and sticky overflow flag.
// Latency: count_en rises at the edge sampling the th-th consecutive high (+2 edges with
// PULSE_QUAL_SYNC_EN defined). Backpressure: none, strobe output is never stalled.
// Ports: clk, rst_n (async active-low), clear (sync clear of count/overflow), thresh_high,
// thresh_low (0 treated as 1), pulse in; count_en strobe, count, overflow out.
module pulse_qual_channel
  import pulse_qual_pkg::*;
#(
  parameter int THR_W = THR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [THR_W-1:0] thresh_high,
  input  logic [THR_W-1:0] thresh_low,
  input  logic             pulse,
  output logic             count_en,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic pulse_s;

`ifdef PULSE_QUAL_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], pulse};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign pulse_s = sync_q[1];
`else
  assign pulse_s = pulse;
`endif

  pq_state_e        state_q, state_d;
  logic [THR_W-1:0] hcnt_q, hcnt_d;
  logic [THR_W-1:0] lcnt_q, lcnt_d;
  logic             count_en_q, count_en_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [THR_W:0]   th, tl;
  logic [THR_W-1:0] hcnt_nxt, lcnt_nxt;
  logic             qualify;

  // A threshold of 0 behaves as 1. The run counters never exceed th-1 / tl-1, so the
  // incremented value always fits in THR_W bits.
  always_comb begin
    th       = (thresh_high == '0) ? (THR_W+1)'(1) : {1'b0, thresh_high};
    tl       = (thresh_low  == '0) ? (THR_W+1)'(1) : {1'b0, thresh_low};
    hcnt_nxt = hcnt_q + THR_W'(1);
    lcnt_nxt = lcnt_q + THR_W'(1);
  end

  // hcnt is 0 in ARM and lcnt is 0 in DONE, so ARM/HIGH and DONE/LOW share their
  // threshold test: the first high (or low) yields a count of 1.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    qualify = 1'b0;
    case (state_q)
      ARM, HIGH: begin
        if (pulse_s) begin
          if ({1'b0, hcnt_nxt} >= th) begin
            qualify = 1'b1;
            state_d = DONE;
            hcnt_d  = '0;
          end else begin
            state_d = HIGH;
            hcnt_d  = hcnt_nxt;
          end
        end else begin
          // glitch shorter than th: drop it without a strobe
          state_d = ARM;
          hcnt_d  = '0;
        end
      end
      DONE, LOW: begin
        if (!pulse_s) begin
          if ({1'b0, lcnt_nxt} >= tl) begin
            state_d = ARM;
            lcnt_d  = '0;
          end else begin
            state_d = LOW;
            lcnt_d  = lcnt_nxt;
          end
        end else begin
          // bounce during the low gap: the pulse is still the one already counted
          state_d = DONE;
          lcnt_d  = '0;
        end
      end
      default: begin
        state_d = ARM;
        hcnt_d  = '0;
        lcnt_d  = '0;
      end
    endcase
  end

  // Clear has priority over a simultaneous qualify; the strobe itself is unaffected.
  always_comb begin
    count_en_d = qualify;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (qualify) begin
      count_d = count_q + CNT_W'(1);
      if (count_q == '1) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARM;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      count_en_q <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      count_en_q <= count_en_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count_en = count_en_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/pulse_qualifier_counter.sv
// Multi-channel pulse qualifier: NUM_CH independent pulse_qual_channel instances with packed
// outputs. Optional input synchronizers via macro PULSE_QUAL_SYNC_EN (adds 2 cycles latency).
// Latency: Count_en high from edge E(th) after Pulse rises before E1. Backpressure: none.
// Ports: CLK, Reset (async active-low), Clear, Thresh_high, Thresh_low, Pulse[NUM_CH] in;
// Count_en[NUM_CH], Count[NUM_CH*CNT_W] (channel 0 in LSBs), Overflow[NUM_CH] out.
module pulse_qualifier_counter
  import pulse_qual_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int THR_W  = THR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    Clear,
  input  logic [THR_W-1:0]        Thresh_high,
  input  logic [THR_W-1:0]        Thresh_low,
  input  logic [NUM_CH-1:0]       Pulse,
  output logic [NUM_CH-1:0]       Count_en,
  output logic [NUM_CH*CNT_W-1:0] Count,
  output logic [NUM_CH-1:0]       Overflow
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_qual_channel #(
      .THR_W (THR_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (CLK),
      .rst_n       (Reset),
      .clear       (Clear),
      .thresh_high (Thresh_high),
      .thresh_low  (Thresh_low),
      .pulse       (Pulse[g]),
      .count_en    (Count_en[g]),
      .count       (Count[g*CNT_W +: CNT_W]),
      .overflow    (Overflow[g])
    );
  end

endmodule

// File: tb/tb_pulse_qualifier_counter.sv
// Self-checking bench for pulse_qualifier_counter (3 channels, 4-bit counters).
// Latency: n/a. Backpressure: n/a.
// Table-driven per-cycle vectors through an expected-strobe queue, plus corner-case sequences.
module tb_pulse_qualifier_counter;

  localparam int NUM_CH = 3;
  localparam int THR_W  = 4;
  localparam int CNT_W  = 4;
`ifdef PULSE_QUAL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic                    CLK = 1'b0;
  logic                    Reset;
  logic                    Clear;
  logic [THR_W-1:0]        Thresh_high;
  logic [THR_W-1:0]        Thresh_low;
  logic [NUM_CH-1:0]       Pulse;
  logic [NUM_CH-1:0]       Count_en;
  logic [NUM_CH*CNT_W-1:0] Count;
  logic [NUM_CH-1:0]       Overflow;

  pulse_qualifier_counter #(
    .NUM_CH (NUM_CH),
    .THR_W  (THR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Clear       (Clear),
    .Thresh_high (Thresh_high),
    .Thresh_low  (Thresh_low),
    .Pulse       (Pulse),
    .Count_en    (Count_en),
    .Count       (Count),
    .Overflow    (Overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] th;
    logic [3:0] tl;
    logic [2:0] pulse;
    logic [2:0] exp_en;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         exp_cnt[NUM_CH];
  logic [NUM_CH-1:0] exp_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input int n, input int th, input int tl,
                              input logic [2:0] p, input logic [2:0] e);
    vec_t v;
    v.th     = 4'(th);
    v.tl     = 4'(tl);
    v.pulse  = p;
    v.exp_en = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // Reference counter behaviour: clear wins, otherwise each strobe adds one, wrap sets sticky flag.
  function automatic void bump(input logic [2:0] en, input logic clr);
    for (int c = 0; c < NUM_CH; c++) begin
      if (clr) begin
        exp_cnt[c] = 0;
        exp_ovf[c] = 1'b0;
      end else if (en[c]) begin
        if (exp_cnt[c] == 15) begin
          exp_cnt[c] = 0;
          exp_ovf[c] = 1'b1;
        end else begin
          exp_cnt[c] = exp_cnt[c] + 1;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("%s count%0d", tag, c), 32'(Count[c*CNT_W +: CNT_W]), exp_cnt[c]);
    chk({tag, " overflow"}, 32'(Overflow), 32'(exp_ovf));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] e;
    for (int c = 0; c < NUM_CH; c++) exp_cnt[c] = 0;
    exp_ovf     = '0;
    Reset       = 1'b0;
    Clear       = 1'b0;
    Pulse       = '0;
    Thresh_high = 4'd4;
    Thresh_low  = 4'd2;

    // reset state
    tick();
    tick();
    chk("reset count_en", 32'(Count_en), 0);
    check_all("reset");
    @(negedge CLK);
    Reset = 1'b1;
    tick();

    // idle
    add(4, 4, 2, 3'd0, 3'd0);
    // th=4: 3-cycle high is a glitch
    add(3, 4, 2, 3'd1, 3'd0); add(5, 4, 2, 3'd0, 3'd0);
    // th=4 tl=2: high 8, low 2, high 8 -> strobe at 4th high of each
    add(3, 4, 2, 3'd1, 3'd0); add(1, 4, 2, 3'd1, 3'd1); add(4, 4, 2, 3'd1, 3'd0);
    add(2, 4, 2, 3'd0, 3'd0);
    add(3, 4, 2, 3'd1, 3'd0); add(1, 4, 2, 3'd1, 3'd1); add(4, 4, 2, 3'd1, 3'd0);
    add(5, 4, 2, 3'd0, 3'd0);
    // th=4 tl=3 on ch1: high 5, low 1 (bounce), high 5 -> one strobe
    add(3, 4, 3, 3'd2, 3'd0); add(1, 4, 3, 3'd2, 3'd2); add(1, 4, 3, 3'd2, 3'd0);
    add(1, 4, 3, 3'd0, 3'd0); add(5, 4, 3, 3'd2, 3'd0); add(5, 4, 3, 3'd0, 3'd0);
    // thresholds 0 act as 1 on ch2: single-cycle highs qualify, one low re-arms
    add(1, 0, 0, 3'd4, 3'd4); add(1, 0, 0, 3'd0, 3'd0); add(1, 0, 0, 3'd4, 3'd4);
    add(1, 0, 0, 3'd4, 3'd0); add(5, 0, 0, 3'd0, 3'd0);
    // th=2 tl=1: all channels simultaneously
    add(1, 2, 1, 3'd7, 3'd0); add(1, 2, 1, 3'd7, 3'd7); add(2, 2, 1, 3'd7, 3'd0);
    add(5, 2, 1, 3'd0, 3'd0);
    // th=3: staggered ch0/ch1 strobe on consecutive cycles
    add(1, 3, 2, 3'd1, 3'd0); add(1, 3, 2, 3'd3, 3'd0); add(1, 3, 2, 3'd3, 3'd1);
    add(1, 3, 2, 3'd2, 3'd2); add(5, 3, 2, 3'd0, 3'd0);
    // long high produces one strobe
    add(3, 4, 2, 3'd1, 3'd0); add(1, 4, 2, 3'd1, 3'd1); add(16, 4, 2, 3'd1, 3'd0);
    add(5, 4, 2, 3'd0, 3'd0);

    foreach (vecs[k]) begin
      Thresh_high = vecs[k].th;
      Thresh_low  = vecs[k].tl;
      Pulse       = vecs[k].pulse;
      exp_q.push_back(vecs[k].exp_en);
      tick();
      if (exp_q.size() > LAT) begin
        e = exp_q.pop_front();
        bump(e, 1'b0);
        chk($sformatf("vec%0d count_en", k), 32'(Count_en), 32'(e));
        check_all($sformatf("vec%0d", k));
      end
    end
    for (int i = 0; i < LAT; i++) begin
      Pulse = '0;
      exp_q.push_back(3'd0);
      tick();
      e = exp_q.pop_front();
      bump(e, 1'b0);
      chk("flush count_en", 32'(Count_en), 32'(e));
      check_all("flush");
    end
    exp_q.delete();

    // lowering Thresh_high mid-pulse qualifies on the next edge
    Thresh_high = 4'd8;
    Thresh_low  = 4'd2;
    Pulse       = 3'd1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      chk("thlow pre count_en", 32'(Count_en), 0);
    end
    Thresh_high = 4'd2;
    tick();
    chk("thlow strobe", 32'(Count_en), 1);
    bump(3'd1, 1'b0);
    Pulse = '0;
    Thresh_high = 4'd4;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      chk("thlow post count_en", 32'(Count_en), 0);
    end
    check_all("thlow");

    // wrap of ch0 counter
    Thresh_high = 4'd1;
    Thresh_low  = 4'd1;
    begin
      int n;
      n = 16 - exp_cnt[0];
      for (int i = 0; i < n; i++) begin
        Pulse = 3'd1;
        tick();
        Pulse = 3'd0;
        tick();
        bump(3'd1, 1'b0);
      end
    end
    for (int i = 0; i < LAT; i++) tick();
    chk("wrap count0", 32'(Count[CNT_W-1:0]), 0);
    chk("wrap overflow", 32'(Overflow), 1);
    check_all("wrap");

    // overflow is sticky across further counts
    Pulse = 3'd1;
    tick();
    Pulse = 3'd0;
    tick();
    for (int i = 0; i < LAT; i++) tick();
    bump(3'd1, 1'b0);
    chk("sticky count0", 32'(Count[CNT_W-1:0]), 1);
    check_all("sticky");

    // clear coinciding with a qualify: strobe still issued, clear wins
    Pulse = 3'd1;
    for (int i = 0; i <= LAT; i++) begin
      Clear = (i == LAT);
      tick();
      Pulse = 3'd0;
      if (i == LAT) chk("clear+qual count_en", 32'(Count_en), 1);
    end
    Clear = 1'b0;
    bump(3'd1, 1'b1);
    check_all("clear");
    for (int i = 0; i < LAT + 3; i++) tick();

    // identical pulses on all channels -> simultaneous strobes
    Thresh_high = 4'd4;
    Thresh_low  = 4'd2;
    Pulse       = 3'd7;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      chk($sformatf("simul c%0d count_en", i), 32'(Count_en), (i == LAT + 3) ? 7 : 0);
    end
    Pulse = 3'd0;
    bump(3'd7, 1'b0);
    for (int i = 0; i < LAT + 3; i++) tick();
    check_all("simul");

    // reset in the middle of the second pulse discards it
    Pulse = 3'd7;
    for (int i = 0; i < LAT + 2; i++) tick();
    #2;
    Reset = 1'b0;
    #1;
    for (int c = 0; c < NUM_CH; c++) exp_cnt[c] = 0;
    exp_ovf = '0;
    chk("midreset count_en", 32'(Count_en), 0);
    check_all("midreset");
    Pulse = 3'd0;
    @(negedge CLK);
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("postreset count_en", 32'(Count_en), 0);
    end
    check_all("postreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
